dmem_ctrl: RTL and testbench

- Parametrised byte-addressed data memory with a request/response handshake and configurable access latency.
- Successor to the fixed 32-byte, single-cycle, word-only big-endian data memory on the processor datapath.
- Adds byte, halfword and word accesses, sign/zero extension on loads, alignment error detection, wait-state modelling and a saturating error counter.
- Sits between the ALU address output and the writeback mux of the multicycle core.

---
 rtl/dmem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed big-endian data memory with request/response handshake and wait states
//
// Purpose: multi-size (byte/half/word) load/store memory for the multicycle core.
// A request is accepted in IDLE, held for WAIT_CYCLES cycles in WAIT, and committed
// in ACCESS, which also registers the one-cycle response pulse.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid / req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_signed      store/load, 00 byte 01 half 10 word 11 illegal, sign-extend loads
//   req_addr, req_wdata               byte address, right-justified store data
//   rsp_valid, rsp_rdata, rsp_err     one-cycle response pulse, load result, error flag (held)
//   err_count                         saturating count of errored requests
module dmem_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 1,
    parameter int ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

    logic [7:0]            mem [DEPTH];
    logic                  mem_we;

    logic [ADDR_W-1:0]     a0, a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic                  access_err;
    logic [31:0]           load_data;

    // Big-endian byte lanes: the byte at the access address is the most significant.
    // Aligned accesses never cross the top, so plain modulo arithmetic suffices.
    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    assign access_err = (size_q == 2'b11)
                      || ((size_q == 2'b01) && addr_q[0])
                      || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));

    always_comb begin
        load_data = 32'd0;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & b0[7]}}, b0};
            2'b01:   load_data = {{16{signed_q & b0[7]}}, b0, b1};
            2'b10:   load_data = {b0, b1, b2, b3};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (HAS_WAIT) begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = access_err;
                if (access_err) begin
                    rsp_rdata_d = 32'd0;
                    err_count_d = (&err_count_q) ? err_count_q : err_count_q + ERRCNT_W'(1);
                end else begin
                    rsp_rdata_d = we_q ? 32'd0 : load_data;
                    mem_we      = we_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage is deliberately not reset. A reset during WAIT/ACCESS forces the
    // state to IDLE asynchronously, which also drops mem_we, so no partial store lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            case (size_q)
                2'b00: mem[a0] <= wdata_q[7:0];
                2'b01: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                2'b10: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_count;

    logic        z_valid, z_ready, z_we, z_signed;
    logic [1:0]  z_size;
    logic [4:0]  z_addr;
    logic [31:0] z_wdata;
    logic        z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;
    logic [7:0]  z_err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [32];
    int         m_errs = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(5), .WAIT_CYCLES(1), .ERRCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_count(err_count)
    );

    dmem_ctrl #(.ADDR_W(5), .WAIT_CYCLES(0), .ERRCNT_W(8)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
        .req_size(z_size), .req_signed(z_signed), .req_addr(z_addr),
        .req_wdata(z_wdata), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .err_count(z_err_count)
    );

    // ---------------- reference model ----------------
    function automatic logic m_bad(input logic [1:0] sz, input int ad);
        return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input int ad);
        longint v;
        v = 0;
        if (sz == 2'd0) begin
            v = mdl[ad];
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = mdl[ad] * 256 + mdl[ad + 1];
            if (sg && v >= 32768) v = v - 65536;
        end else if (sz == 2'd2) begin
            v = ((longint'(mdl[ad]) * 256 + mdl[ad + 1]) * 256 + mdl[ad + 2]) * 256 + mdl[ad + 3];
        end
        return v[31:0];
    endfunction

    task automatic m_apply(input logic we, input logic [1:0] sz, input logic sg, input int ad,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        rd = 32'd0;
        er = m_bad(sz, ad);
        if (er) begin
            if (m_errs < 255) m_errs++;
        end else if (we) begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) mdl[ad + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        end else begin
            rd = m_load(sz, sg, ad);
        end
    endtask

    // ---------------- stimulus driver ----------------
    // Returns the response fields and the number of cycles from the accepting
    // cycle to the cycle carrying rsp_valid.
    task automatic txn(input logic we, input logic [1:0] sz, input logic sg, input logic [4:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = 5'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic z_txn(input logic we, input logic [1:0] sz, input logic sg, input logic [4:0] ad,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!z_ready && n < 50) begin @(negedge clk); n++; end
        z_valid = 1'b1; z_we = we; z_size = sz; z_signed = sg; z_addr = ad; z_wdata = wd;
        @(negedge clk);
        z_valid = 1'b0;
        lat = 1;
        while (!z_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        rd = z_rsp_rdata;
        er = z_rsp_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        z_valid = 0; z_we = 0; z_size = 0; z_signed = 0; z_addr = 0; z_wdata = 0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_mem();
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat;
        for (int a = 0; a < 32; a += 4) begin
            wd = $urandom;
            m_apply(1'b1, 2'd2, 1'b0, a, wd, erd, eer);
            txn(1'b1, 2'd2, 1'b0, 5'(a), wd, rd, er, lat);
            checks++; if (er !== 1'b0 || lat != 3) begin errors++; $display("FAIL init_store@%0d: err %b lat %0d want err 0 lat 3", a, er, lat); end
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic er, eer;
        logic [31:0] erd;
        int lat;
        m_apply(1'b1, 2'd2, 1'b0, 4, 32'hDEADBEEF, erd, eer);
        txn(1'b1, 2'd2, 1'b0, 5'h04, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL store_latency: got %0d want 3", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_rsp: err %b rdata %h want 0/0", er, rd); end
        txn(1'b0, 2'd2, 1'b0, 5'h04, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load: got %h want deadbeef", rd); end
        txn(1'b0, 2'd0, 1'b0, 5'h04, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL byte4: got %h want 000000de", rd); end
        txn(1'b0, 2'd0, 1'b1, 5'h05, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFAD) begin errors++; $display("FAIL sbyte5: got %h want ffffffad", rd); end
        txn(1'b0, 2'd0, 1'b0, 5'h05, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h000000AD) begin errors++; $display("FAIL ubyte5: got %h want 000000ad", rd); end
        txn(1'b0, 2'd1, 1'b1, 5'h06, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL shalf6: got %h want ffffbeef", rd); end
        txn(1'b0, 2'd1, 1'b0, 5'h06, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL uhalf6: got %h want 0000beef", rd); end
        txn(1'b0, 2'd2, 1'b1, 5'h04, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL signed_word_ignored: got %h want deadbeef", rd); end
        m_apply(1'b1, 2'd0, 1'b0, 7, 32'h12345677, erd, eer);
        txn(1'b1, 2'd0, 1'b0, 5'h07, 32'h12345677, rd, er, lat);
        txn(1'b0, 2'd2, 1'b0, 5'h04, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBE77) begin errors++; $display("FAIL partial_store: got %h want deadbe77", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd, before8;
        logic er, eer;
        int lat;
        before8 = m_load(2'd2, 1'b0, 8);
        m_apply(1'b0, 2'd2, 1'b0, 2, 32'd0, erd, eer);
        txn(1'b0, 2'd2, 1'b0, 5'h02, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 3) begin errors++; $display("FAIL err_word2: err %b rdata %h lat %0d want 1/0/3", er, rd, lat); end
        m_apply(1'b1, 2'd1, 1'b0, 9, 32'hFFFFA5A5, erd, eer);
        txn(1'b1, 2'd1, 1'b0, 5'h09, 32'hFFFFA5A5, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_half9: err %b rdata %h want 1/0", er, rd); end
        m_apply(1'b0, 2'd3, 1'b0, 0, 32'd0, erd, eer);
        txn(1'b0, 2'd3, 1'b0, 5'h00, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_size3: err %b rdata %h want 1/0", er, rd); end
        checks++; if (err_count !== 8'(m_errs)) begin errors++; $display("FAIL err_count3: got %0d want %0d", err_count, m_errs); end
        txn(1'b0, 2'd2, 1'b0, 5'h08, 32'd0, rd, er, lat);
        checks++; if (rd !== before8) begin errors++; $display("FAIL mem8_unchanged: got %h want %h", rd, before8); end
    endtask

    task automatic test_handshake();
        logic [31:0] exp1, rd;
        int lat;
        logic er;
        @(negedge clk);
        exp1 = m_load(2'd2, 1'b0, 4);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 5'h04; req_wdata = 32'd0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_wait: got %b want 0", req_ready); end
        req_we = 1'b1; req_addr = 5'h08; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL hs_access: ready %b rsp_valid %b want 0/0", req_ready, rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp1 || rsp_err !== 1'b0) begin errors++; $display("FAIL hs_first_rsp: valid %b rdata %h want 1/%h", rsp_valid, rsp_rdata, exp1); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_idle: got %b want 1", req_ready); end
        m_apply(1'b1, 2'd2, 1'b0, 8, 32'hCAFEF00D, rd, er);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== exp1 || req_ready !== 1'b0) begin errors++; $display("FAIL hs_hold: valid %b rdata %h ready %b want 0/%h/0", rsp_valid, rsp_rdata, req_ready, exp1); end
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (lat != 3 || rsp_err !== 1'b0) begin errors++; $display("FAIL hs_second: lat %0d err %b want 3/0", lat, rsp_err); end
        txn(1'b0, 2'd2, 1'b0, 5'h08, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL hs_second_data: got %h want cafef00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd;
        logic er, eer, we, sg;
        logic [1:0] sz;
        int ad, lat;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); wd = $urandom;
            ad = $urandom_range(0, 31);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad = ad & ~1;
                if (sz == 2'd2) ad = ad & ~3;
            end
            m_apply(we, sz, sg, ad, wd, erd, eer);
            txn(we, sz, sg, 5'(ad), wd, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat != 3 || err_count !== 8'(m_errs)) begin
                errors++;
                $display("FAIL rand[%0d] we%b sz%0d sg%b a%0d: rdata %h err %b lat %0d cnt %0d want %h %b 3 %0d",
                         i, we, sz, sg, ad, rd, er, lat, err_count, erd, eer, m_errs);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        for (int i = 0; i < 260; i++) begin
            m_apply(1'b0, 2'd3, 1'b0, 0, 32'd0, erd, eer);
            txn(1'b0, 2'd3, 1'b0, 5'($urandom), 32'd0, rd, er, lat);
        end
        checks++; if (err_count !== 8'(m_errs) || err_count !== 8'hFF) begin errors++; $display("FAIL err_saturate: got %0d want %0d", err_count, m_errs); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, wd;
        logic er;
        int lat;
        wd = $urandom;
        z_txn(1'b1, 2'd2, 1'b0, 5'h10, wd, rd, er, lat);
        checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL zw_store: lat %0d err %b want 2/0", lat, er); end
        z_txn(1'b0, 2'd2, 1'b0, 5'h10, 32'd0, rd, er, lat);
        checks++; if (lat != 2 || rd !== wd) begin errors++; $display("FAIL zw_load: lat %0d rdata %h want 2/%h", lat, rd, wd); end
        z_txn(1'b0, 2'd1, 1'b0, 5'h12, 32'd0, rd, er, lat);
        checks++; if (rd !== (wd % 65536)) begin errors++; $display("FAIL zw_half: got %h want %h", rd, wd % 65536); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp0;
        logic er, seen;
        int n, lat;
        exp0 = m_load(2'd2, 1'b0, 0);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 5'h00; req_wdata = 32'h11111111;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_on_assert: got %b want 1", req_ready); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        rst_n = 1'b1;
        m_errs = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_rsp: rsp_valid seen %b want 0", seen); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rm_err_count: got %0d want 0", err_count); end
        txn(1'b0, 2'd2, 1'b0, 5'h00, 32'd0, rd, er, lat);
        checks++; if (rd !== exp0 || er !== 1'b0) begin errors++; $display("FAIL rm_mem_kept: got %h want %h", rd, exp0); end
    endtask

    initial begin
        test_reset();
        test_init_mem();
        test_directed();
        test_errors();
        test_handshake();
        test_random();
        test_saturation();
        test_zero_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
